// File: rtl/read_bench_pkg.sv
// Shared definitions for the read bench engine: the FSM state encoding,
// the pattern_mode values, the generator and CRC polynomials, and the
// LFSR step helper.
package read_bench_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_COUNTER = 2'd0;
    localparam logic [1:0] MODE_LFSR    = 2'd1;
    localparam logic [1:0] MODE_WALK    = 2'd2;
    localparam logic [1:0] MODE_CONST   = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    // One right-shifting Galois step: the bit shifted out of bit 0 selects
    // whether the tap mask is folded back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/read_bench_pattern_gen.sv
// Wide-word pattern source for the read bench engine. All four generators
// advance together on every accepted write so a mode change mid-run picks up
// each pattern at the same write index; reload restarts all of them.
module read_bench_pattern_gen
    import read_bench_pkg::*;
#(
    parameter int W = 64
) (
    input  logic          okClk,
    input  logic [1:0]    mode,
    input  logic [31:0]   seed,
    input  logic          advance,
    input  logic          reload,
    output logic [W-1:0]  word
);

    localparam int KW    = (W > 1) ? $clog2(W) : 1;
    localparam int LANES = (W + 31) / 32;

    logic [W-1:0]        cnt;
    logic [31:0]         lfsr;
    logic [KW-1:0]       k;
    logic [LANES*32-1:0] lfsr_rep;
    logic [LANES*32-1:0] seed_rep;

    // 32-bit sources are replicated across every lane of the wide word.
    assign lfsr_rep = {LANES{lfsr}};
    assign seed_rep = {LANES{seed}};

    // Generator state: reload wins over advance; a zero seed would lock the LFSR.
    always_ff @(posedge okClk) begin
        if (reload) begin
            cnt  <= '0;
            lfsr <= (seed == 32'd0) ? 32'd1 : seed;
            k    <= '0;
        end else if (advance) begin
            cnt  <= cnt + 1'b1;
            lfsr <= lfsr_step(lfsr);
            k    <= (k == KW'(W - 1)) ? '0 : k + 1'b1;
        end
    end

    // Select the current word for the active mode.
    always_comb begin
        word = '0;
        case (mode)
            MODE_COUNTER: word = cnt;
            MODE_LFSR:    word = lfsr_rep[W-1:0];
            MODE_WALK:    word = W'(1) << k;
            MODE_CONST:   word = seed_rep[W-1:0];
            default:      word = '0;
        endcase
    end

endmodule

// File: rtl/read_bench_engine.sv
// Read bench engine: generates wide pattern words into a buffer while a
// narrow reader drains it, timing the run and optionally CRC-ing what was read.
// Optional feature: define READ_BENCH_CRC_EN to build the read-side CRC-32;
// otherwise crc is tied to zero.
module read_bench_engine
    import read_bench_pkg::*;
#(
    parameter int RD_WIDTH = 32,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 1024
) (
    input  logic                okClk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                reset_pattern,
    input  logic [1:0]          pattern_mode,
    input  logic [31:0]         seed,
    input  logic [31:0]         word_limit,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                empty,
    output logic                underflow,
    output logic                timer_on,
    output logic [1:0]          state,
    output logic [63:0]         clk_counts,
    output logic [31:0]         words_generated,
    output logic [31:0]         crc
);

    localparam int W  = RATIO * RD_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    state_t              st;
    logic [RD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       fill;
    logic                has_room;
    logic                limit_hit;
    logic                start_ok;
    logic                wr_fire;
    logic                rd_fire;
    logic [W-1:0]        gen_word;

    // Pointers carry one extra bit so a full buffer is distinguishable from empty.
    assign fill      = wr_ptr - rd_ptr;
    assign empty     = (fill == '0);
    assign has_room  = (fill <= PW'(DEPTH - RATIO));
    assign limit_hit = (word_limit != 32'd0) && (words_generated == word_limit);
    assign start_ok  = ((st == ST_IDLE) || (st == ST_DONE)) && start && !stop;
    // A flush cycle neither writes nor reads so the buffer is truly empty after it.
    assign wr_fire   = (st == ST_RUN) && !limit_hit && has_room && !reset_pattern;
    assign rd_fire   = rd_en && !empty && !reset_pattern;
    assign state     = st;

    read_bench_pattern_gen #(
        .W (W)
    ) u_gen (
        .okClk   (okClk),
        .mode    (pattern_mode),
        .seed    (seed),
        .advance (wr_fire),
        .reload  (reset || reset_pattern),
        .word    (gen_word)
    );

    // Buffer pointers: a write claims RATIO narrow slots, a read frees one.
    always_ff @(posedge okClk) begin
        if (reset || reset_pattern) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PW'(RATIO);
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Split each wide word into narrow slots, lowest slice at the lowest address.
    always_ff @(posedge okClk) begin
        if (wr_fire) begin
            for (int s = 0; s < RATIO; s++) begin
                mem[wr_ptr[AW-1:0] + AW'(s)] <= gen_word[s*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

    // Registered read port; reading while empty only raises the sticky flag.
    always_ff @(posedge okClk) begin
        if (reset) begin
            rd_data   <= '0;
            underflow <= 1'b0;
        end else begin
            if (rd_fire) rd_data <= mem[rd_ptr[AW-1:0]];
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    // Run control FSM with cycle timer and write counter.
    always_ff @(posedge okClk) begin
        if (reset) begin
            st              <= ST_IDLE;
            timer_on        <= 1'b0;
            clk_counts      <= '0;
            words_generated <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        st              <= ST_RUN;
                        timer_on        <= 1'b1;
                        clk_counts      <= 64'd1;
                        words_generated <= '0;
                    end
                end
                ST_RUN: begin
                    clk_counts <= clk_counts + 64'd1;
                    if (wr_fire) words_generated <= words_generated + 32'd1;
                    if (stop || limit_hit) st <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    clk_counts <= clk_counts + 64'd1;
                    if (empty || stop) begin
                        st       <= ST_DONE;
                        timer_on <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef READ_BENCH_CRC_EN
    logic [31:0] crc_q;

    // CRC-32 over one read word, most significant bit first, no reflection.
    function automatic logic [31:0] crc_word(input logic [31:0] c,
                                             input logic [RD_WIDTH-1:0] d);
        logic [31:0]         r;
        logic [RD_WIDTH-1:0] t;
        r = c;
        t = d;
        for (int i = 0; i < RD_WIDTH; i++) begin
            if (r[31] ^ t[RD_WIDTH-1]) r = (r << 1) ^ CRC_POLY;
            else                       r = r << 1;
            t = t << 1;
        end
        return r;
    endfunction

    // Fold each word into the CRC on the same edge that loads rd_data.
    always_ff @(posedge okClk) begin
        if (reset || reset_pattern) begin
            crc_q <= '0;
        end else if (start_ok) begin
            crc_q <= CRC_INIT;
        end else if (rd_fire) begin
            crc_q <= crc_word(crc_q, mem[rd_ptr[AW-1:0]]);
        end
    end

    assign crc = crc_q;
`else
    assign crc = 32'd0;
`endif

endmodule

// File: tb/tb_read_bench_engine.sv
// Scoreboard bench for read_bench_engine (RD_WIDTH=32, RATIO=2, DEPTH=1024).
// Reads push their expected word; a monitor pops and compares rd_data.
module tb_read_bench_engine;

    logic        okClk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        reset_pattern = 1'b0;
    logic [1:0]  pattern_mode = 2'd0;
    logic [31:0] seed = 32'd0;
    logic [31:0] word_limit = 32'd0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        empty;
    logic        underflow;
    logic        timer_on;
    logic [1:0]  state;
    logic [63:0] clk_counts;
    logic [31:0] words_generated;
    logic [31:0] crc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tbl[$];

    always #5 okClk = ~okClk;

    read_bench_engine #(
        .RD_WIDTH (32),
        .RATIO    (2),
        .DEPTH    (1024)
    ) dut (
        .okClk           (okClk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .reset_pattern   (reset_pattern),
        .pattern_mode    (pattern_mode),
        .seed            (seed),
        .word_limit      (word_limit),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .empty           (empty),
        .underflow       (underflow),
        .timer_on        (timer_on),
        .state           (state),
        .clk_counts      (clk_counts),
        .words_generated (words_generated),
        .crc             (crc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge okClk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        reset_pattern = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] e);
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, {62'd0, state}, {62'd0, s});
    endtask

    // Run one bounded transfer and read back the words listed in tbl.
    task automatic run_table(input string name, input logic [1:0] mode,
                             input logic [31:0] sd, input logic [31:0] limit);
        do_reset();
        pattern_mode = mode;
        seed = sd;
        word_limit = limit;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(2'd2, 100, {name, "_drain"});
        foreach (tbl[i]) issue_read(tbl[i]);
        tick();
        check({name, "_done"}, {62'd0, state}, 64'd3);
        check({name, "_words"}, {32'd0, words_generated}, {32'd0, limit});
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            logic fb;
            fb = r[31] ^ d[i];
            r = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    // Monitor: a read accepted at a rising edge is compared at the next falling edge.
    initial begin : monitor
        logic        fired;
        logic [31:0] e;
        forever begin
            @(posedge okClk);
            fired = rd_en && !empty && !reset && !reset_pattern;
            @(negedge okClk);
            if (fired) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_data: unexpected read word %0h, expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        errors++;
                        $display("FAIL rd_data: got %0h, expected %0h", rd_data, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [63:0] snap;
        logic [31:0] c;
        int          n;

        // Reset state
        do_reset();
        check("rst_state", {62'd0, state}, 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_underflow", {63'd0, underflow}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_clk_counts", clk_counts, 64'd0);
        check("rst_words", {32'd0, words_generated}, 64'd0);
        check("rst_crc", {32'd0, crc}, 64'd0);
        check("rst_timer_on", {63'd0, timer_on}, 64'd0);

        // Read while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("uf_flag", {63'd0, underflow}, 64'd1);
        check("uf_rd_data", {32'd0, rd_data}, 64'd0);
        tick();
        check("uf_sticky", {63'd0, underflow}, 64'd1);

        // start and stop together in IDLE
        do_reset();
        check("uf_cleared", {63'd0, underflow}, 64'd0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("ss_state", {62'd0, state}, 64'd0);
        check("ss_clk_counts", clk_counts, 64'd0);
        check("ss_timer_on", {63'd0, timer_on}, 64'd0);

        // Counter mode, fill to capacity, then drain everything
        do_reset();
        pattern_mode = 2'd0;
        word_limit = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fill_state_run", {62'd0, state}, 64'd1);
        check("fill_clk_start", clk_counts, 64'd1);
        check("fill_timer_on", {63'd0, timer_on}, 64'd1);
        n = 0;
        while (words_generated !== 32'd512 && n < 700) begin
            tick();
            n++;
        end
        check("fill_words", {32'd0, words_generated}, 64'd512);
        repeat (5) tick();
        check("fill_words_hold", {32'd0, words_generated}, 64'd512);
        check("fill_not_empty", {63'd0, empty}, 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("fill_drain", {62'd0, state}, 64'd2);
        for (int i = 0; i < 512; i++) begin
            issue_read(i);
            issue_read(32'd0);
        end
        tick();
        check("fill_done", {62'd0, state}, 64'd3);
        check("fill_empty", {63'd0, empty}, 64'd1);
        check("fill_underflow", {63'd0, underflow}, 64'd0);
        check("fill_timer_off", {63'd0, timer_on}, 64'd0);
        snap = clk_counts;
        repeat (3) tick();
        check("fill_clk_frozen", clk_counts, snap);

        // word_limit=4 with continuous reads, cycle-exact
        do_reset();
        pattern_mode = 2'd0;
        word_limit = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lim_clk_start", clk_counts, 64'd1);
        tick();
        check("lim_first_write", {32'd0, words_generated}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                check("lim_drain_after_4th", {62'd0, state}, 64'd2);
                check("lim_words_4", {32'd0, words_generated}, 64'd4);
                check("lim_clk_mid", clk_counts, 64'd6);
            end
            issue_read((i % 2 == 0) ? 32'(i / 2) : 32'd0);
        end
        check("lim_still_drain", {62'd0, state}, 64'd2);
        tick();
        check("lim_done", {62'd0, state}, 64'd3);
        check("lim_clk_final", clk_counts, 64'd11);
        repeat (3) tick();
        check("lim_clk_frozen", clk_counts, 64'd11);
        check("lim_words_final", {32'd0, words_generated}, 64'd4);
        check("lim_underflow", {63'd0, underflow}, 64'd0);

        // Constant mode with a flush in the middle of RUN
        do_reset();
        pattern_mode = 2'd3;
        seed = 32'hA5A5_A5A5;
        word_limit = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rp_not_empty", {63'd0, empty}, 64'd0);
        reset_pattern = 1'b1;
        tick();
        reset_pattern = 1'b0;
        check("rp_empty", {63'd0, empty}, 64'd1);
        check("rp_state", {62'd0, state}, 64'd1);
        check("rp_words_kept", {32'd0, words_generated}, 64'd3);
        tick();
        for (int i = 0; i < 6; i++) issue_read(32'hA5A5_A5A5);
        check("rp_underflow", {63'd0, underflow}, 64'd0);

        // Reset in the middle of a run discards buffered data
        do_reset();
        check("mid_rst_state", {62'd0, state}, 64'd0);
        check("mid_rst_empty", {63'd0, empty}, 64'd1);
        check("mid_rst_words", {32'd0, words_generated}, 64'd0);

        // Walking-one, three wide words
        tbl = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd4, 32'd0};
        run_table("walk", 2'd2, 32'd0, 32'd3);

        // LFSR from seed 0 (treated as 1), two wide words
        tbl = '{32'h0000_0001, 32'h0000_0001, 32'h8020_0003, 32'h8020_0003};
        run_table("lfsr", 2'd1, 32'd0, 32'd2);

        // CRC over counter words 0,0,1,0
        tbl = '{32'd0, 32'd0, 32'd1, 32'd0};
        run_table("crc", 2'd0, 32'd0, 32'd2);
`ifdef READ_BENCH_CRC_EN
        c = 32'hFFFF_FFFF;
        c = crc_ref(c, 32'd0);
        c = crc_ref(c, 32'd0);
        c = crc_ref(c, 32'd1);
        c = crc_ref(c, 32'd0);
`else
        c = 32'd0;
`endif
        check("crc_value", {32'd0, crc}, {32'd0, c});

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
